// File: rtl/cache_types_pkg.sv
// Shared types and constants for the L1 cache hierarchy: arbiter state,
// requester identifiers and the pmem line/address geometry.
package cache_types_pkg;

    localparam int PMEM_ADDR_WIDTH = 32;
    localparam int PMEM_LINE_WIDTH = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

    // On a tie the requester that did not win last time is served.
    function automatic arb_state_e tie_winner(input req_id_e last_grant);
        arb_state_e winner;
        if (last_grant == REQ_I) begin
            winner = SERVE_D;
        end else begin
            winner = SERVE_I;
        end
        return winner;
    endfunction

endpackage

// File: rtl/counter.sv
// Generic wrapping event counter with synchronous clear (clear wins over enable).
module counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] count_r;

    // Count register: async reset, clear over increment, natural wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable) begin
            count_r <= count_r + WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign out = count_r;

endmodule

// File: rtl/l1_pmem_arbiter.sv
// Round-robin arbiter sharing one pmem port between the L1I and L1D controllers.
// Grant is held from the arbitration cycle until the downstream response or an abort.
module l1_pmem_arbiter
    import cache_types_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    input  logic                  arb_conflict_clear,
    output logic [31:0]           arb_conflict_count
);

    arb_state_e state_r;
    req_id_e    last_grant_r;
    logic       i_req_s;
    logic       d_req_s;
    logic       conflict_s;

    assign i_req_s    = i_pmem_read;
    assign d_req_s    = d_pmem_read | d_pmem_write;
    assign conflict_s = (state_r == IDLE) & i_req_s & d_req_s;

    // Arbitration FSM and round-robin history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            last_grant_r <= REQ_I;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_req_s && d_req_s) begin
                        state_r <= tie_winner(last_grant_r);
                    end else if (d_req_s) begin
                        state_r <= SERVE_D;
                    end else if (i_req_s) begin
                        state_r <= SERVE_I;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SERVE_I: begin
                    // A response completes the transaction even if the strobe drops with it.
                    if (pmem_resp) begin
                        state_r      <= IDLE;
                        last_grant_r <= REQ_I;
                    end else if (!i_req_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= SERVE_I;
                    end
                end
                SERVE_D: begin
                    if (pmem_resp) begin
                        state_r      <= IDLE;
                        last_grant_r <= REQ_D;
                    end else if (!d_req_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= SERVE_D;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Downstream and response mux driven by the registered grant.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        case (state_r)
            SERVE_I: begin
                pmem_read    = i_pmem_read;
                pmem_address = i_pmem_address;
                i_pmem_resp  = pmem_resp;
            end
            SERVE_D: begin
                pmem_read    = d_pmem_read;
                pmem_write   = d_pmem_write & ~d_pmem_read;
                pmem_address = d_pmem_address;
                pmem_wdata   = d_pmem_wdata;
                d_pmem_resp  = pmem_resp;
            end
            default: begin
                pmem_read = 1'b0;
            end
        endcase
    end

    // Read data fans out unqualified; only the resp pulse marks it valid.
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

    counter #(
        .WIDTH(32)
    ) u_conflict_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (conflict_s),
        .clear  (arb_conflict_clear),
        .out    (arb_conflict_count)
    );

endmodule

// File: doc/l1_pmem_arbiter.md
Name: l1_pmem_arbiter

Overview:
- Shares the single physical-memory (L2/pmem) port between the L1 instruction cache and the L1 data cache controllers.
- Each L1 controller sees a private pmem-style read/write/resp interface.
- The arbiter grants one requester per transaction, holds the grant until the downstream response, and alternates round-robin on conflicts.
- Sits between the L1I/L1D cache controllers and the pmem port at the top of the cache hierarchy.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- LINE_WIDTH, 256, cache line width in bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- i_pmem_read  in  1  L1I line read request.
- i_pmem_address  in  ADDR_WIDTH  L1I line address.
- i_pmem_rdata  out  LINE_WIDTH  line data to L1I.
- i_pmem_resp  out  1  L1I completion pulse.
- d_pmem_read  in  1  L1D line read request.
- d_pmem_write  in  1  L1D line write-back request.
- d_pmem_address  in  ADDR_WIDTH  L1D line address.
- d_pmem_wdata  in  LINE_WIDTH  L1D write-back data.
- d_pmem_rdata  out  LINE_WIDTH  line data to L1D.
- d_pmem_resp  out  1  L1D completion pulse.
- pmem_read  out  1  downstream read strobe.
- pmem_write  out  1  downstream write strobe.
- pmem_address  out  ADDR_WIDTH  downstream address.
- pmem_wdata  out  LINE_WIDTH  downstream write data.
- pmem_rdata  in  LINE_WIDTH  downstream read data.
- pmem_resp  in  1  downstream completion pulse.
- arb_conflict_clear  in  1  synchronous clear of the conflict counter.
- arb_conflict_count  out  32  number of arbitrations where both requested.

Behaviour:
- States: IDLE, SERVE_I, SERVE_D. Plus one last_grant flop (0=I, 1=D).
- Reset (rst_n low, asynchronous):
  - state=IDLE, last_grant=0 (I), so D wins the first tie.
  - All downstream strobes, both resps and the counter go to 0 immediately.
- IDLE: no downstream strobes; resps 0. Arbitration uses the requests sampled this cycle:
  - i_req = i_pmem_read; d_req = d_pmem_read | d_pmem_write.
  - Only d_req -> SERVE_D. Only i_req -> SERVE_I.
  - Both -> grant the one not equal to last_grant, and the counter increments.
  - Neither -> stay in IDLE.
  - Grant costs one cycle: downstream strobes first appear the cycle after the request is seen.
- SERVE_D (combinational mux, no extra latency):
  - pmem_read=d_pmem_read; pmem_write=d_pmem_write & ~d_pmem_read (if both asserted, read wins; this is illegal and the bench flags it).
  - pmem_address=d_pmem_address; pmem_wdata=d_pmem_wdata.
  - d_pmem_resp=pmem_resp; d_pmem_rdata=pmem_rdata.
- SERVE_I:
  - pmem_read=i_pmem_read; pmem_write=0; pmem_address=i_pmem_address; pmem_wdata=0.
  - i_pmem_resp=pmem_resp; i_pmem_rdata=pmem_rdata.
- Non-granted requester: resp held 0; rdata driven with pmem_rdata (don't-care, never qualified).
- Grant release:
  - On pmem_resp in SERVE_x: last_grant<=x, next state IDLE.
  - The mandatory IDLE cycle keeps a requester that holds its strobe through the resp cycle from re-issuing.
- Abort: granted requester drops its request with no pmem_resp -> IDLE next cycle; last_grant is unchanged.
- Back-to-back D transactions (write-back then refill):
  - Write resp, then IDLE, then the D read is regranted if it is still the only requester.
  - If I is also waiting, I is granted first; this round-robin behaviour is intended.
- Starvation bound: a waiting requester is granted within one other transaction.
- Counter:
  - 32-bit, wraps 0xFFFF_FFFF -> 0.
  - Clear has priority over increment in the same cycle.

Decomposition:
- Shared package (cache_types_pkg): arbiter state enum (IDLE/SERVE_I/SERVE_D), requester-ID enum (REQ_I=0, REQ_D=1), LINE_WIDTH/ADDR_WIDTH constants.
- Sub-module: the conflict counter reuses the existing counter module (clk, enable, clear, out); no other sub-modules.

Test Plan:
- Lone I read: i_pmem_read=1, addr 0x0000_0060; pmem_resp after 5 cycles with rdata=0xA5..A5 -> pmem_read high from cycle 1; i_pmem_resp one pulse with 0xA5..A5; d_pmem_resp stays 0; returns to IDLE.
- Simultaneous after reset: both request in cycle 0 -> D granted first. I is granted the cycle after D's resp+IDLE; arb_conflict_count=1.
- Back-to-back D write-back then refill with I waiting:
  - D write 0x0000_1000, I read 0x0000_0200 arrives mid-write.
  - Required order: D write, I read, D read 0x0000_2000.
  - pmem_wdata matches d_pmem_wdata during the write.
- Async reset mid-SERVE_D: rst_n low while pmem_write=1 -> pmem_write drops in the same cycle with no clock edge; after release the state is IDLE and the counter is 0.
- Abort: D granted, d_pmem_read dropped before resp -> IDLE next cycle; a pending I is granted the following cycle.
- Counter: preload to 0xFFFF_FFFF via 2^32-free force, then one conflict -> 0. Conflict together with clear -> 0.
